// File: rtl/issue_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// issue_scoreboard_pkg
//   Shared types and sizes for the issue scoreboard: scoreboard depth,
//   write-back port count, trans_id width, exception record, functional-unit
//   and operation encodings, and the scoreboard_entry record.
// -----------------------------------------------------------------------------
package issue_scoreboard_pkg;

    localparam int NR_SB_ENTRIES = 8;
    localparam int NR_WB_PORTS   = 2;
    localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;

    typedef enum logic [2:0] {
        FU_NONE  = 3'd0,
        FU_ALU   = 3'd1,
        FU_LSU   = 3'd2,
        FU_MULT  = 3'd3,
        FU_CSR   = 3'd4,
        FU_CTRL  = 3'd5
    } fu_t;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_LD    = 4'd5,
        OP_ST    = 4'd6,
        OP_MUL   = 4'd7,
        OP_BR    = 4'd8,
        OP_CSRRW = 4'd9
    } fu_op;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        fu_op                     op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        exception                 ex;
    } scoreboard_entry;

endpackage

// File: rtl/issue_scoreboard_if.sv
// -----------------------------------------------------------------------------
// issue_scoreboard_if
//   Bundles every scoreboard signal except clock and reset.
//   slave  : scoreboard side (issue_scoreboard)
//   master : decode / functional units / commit side
//   Groups: flush; issue handshake (valid/ready/entry/trans_id/full);
//   operand lookup (rs1/rs2, busy, forward); write-back ports; commit.
//   Widths come from issue_scoreboard_pkg.
// -----------------------------------------------------------------------------
interface issue_scoreboard_if;
    import issue_scoreboard_pkg::*;

    logic                                        flush_i;

    logic                                        issue_valid_i;
    logic                                        issue_ready_o;
    scoreboard_entry                             issue_entry_i;
    logic [TRANS_ID_BITS-1:0]                    issue_trans_id_o;
    logic                                        full_o;

    logic [4:0]                                  rs1_i;
    logic [4:0]                                  rs2_i;
    logic                                        rs1_busy_o;
    logic                                        rs2_busy_o;
    logic                                        rs1_fwd_valid_o;
    logic                                        rs2_fwd_valid_o;
    logic [63:0]                                 rs1_fwd_o;
    logic [63:0]                                 rs2_fwd_o;

    logic [NR_WB_PORTS-1:0]                      wb_valid_i;
    logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_i;
    logic [NR_WB_PORTS-1:0][63:0]                wb_data_i;
    exception [NR_WB_PORTS-1:0]                  wb_ex_i;

    logic                                        commit_valid_o;
    scoreboard_entry                             commit_entry_o;
    logic                                        commit_ack_i;

    modport slave (
        input  flush_i, issue_valid_i, issue_entry_i, rs1_i, rs2_i,
               wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i, commit_ack_i,
        output issue_ready_o, issue_trans_id_o, full_o,
               rs1_busy_o, rs2_busy_o, rs1_fwd_valid_o, rs2_fwd_valid_o,
               rs1_fwd_o, rs2_fwd_o, commit_valid_o, commit_entry_o
    );

    modport master (
        output flush_i, issue_valid_i, issue_entry_i, rs1_i, rs2_i,
               wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i, commit_ack_i,
        input  issue_ready_o, issue_trans_id_o, full_o,
               rs1_busy_o, rs2_busy_o, rs1_fwd_valid_o, rs2_fwd_valid_o,
               rs1_fwd_o, rs2_fwd_o, commit_valid_o, commit_entry_o
    );

endinterface

// File: rtl/issue_scoreboard_sb_youngest_match.sv
// -----------------------------------------------------------------------------
// issue_scoreboard_sb_youngest_match
//   Picks the youngest set bit of an rd-match vector in a circular buffer.
//   Ports:
//     match_i    : per-entry match (already qualified by occupancy)
//     head_i     : oldest entry index
//     youngest_o : one-hot of the youngest matching entry, zero if none
//   Only instantiated when SB_FORWARD_EN is defined.
// -----------------------------------------------------------------------------
module issue_scoreboard_sb_youngest_match #(
    parameter int NR_ENTRIES = 8
) (
    input  logic [NR_ENTRIES-1:0]         match_i,
    input  logic [$clog2(NR_ENTRIES)-1:0] head_i,
    output logic [NR_ENTRIES-1:0]         youngest_o
);

    localparam int ID_W = $clog2(NR_ENTRIES);

    // Occupied entries are contiguous from head, so walking upward from head
    // and keeping the last hit yields the youngest one. The index wraps by
    // width because NR_ENTRIES is a power of two.
    always_comb begin
        logic [ID_W-1:0] idx;
        youngest_o = '0;
        idx        = head_i;
        for (int k = 0; k < NR_ENTRIES; k++) begin
            if (match_i[idx]) begin
                youngest_o      = '0;
                youngest_o[idx] = 1'b1;
            end
            idx = idx + 1'b1;
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//   In-order issue / out-of-order write-back scoreboard between decode and
//   commit. Circular buffer of NR_ENTRIES scoreboard_entry records; the slot
//   index is the trans_id. Results and exceptions arrive on NR_WB_PORTS
//   write-back ports; the head entry is offered to commit once written back.
//   Ports:
//     clk_i : clock, rising edge
//     rst_i : synchronous active-high reset
//     sb    : issue_scoreboard_if.slave (issue, operand lookup, write-back,
//             commit, flush)
//   Configuration macro SB_FORWARD_EN: when defined, rs1/rs2 receive the
//   result of the youngest occupied entry writing that register; when
//   undefined, the forward outputs are tied to zero.
// -----------------------------------------------------------------------------
module issue_scoreboard #(
    parameter int NR_ENTRIES  = issue_scoreboard_pkg::NR_SB_ENTRIES,
    parameter int NR_WB_PORTS = issue_scoreboard_pkg::NR_WB_PORTS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    issue_scoreboard_if.slave        sb
);
    import issue_scoreboard_pkg::*;

    localparam int ID_W = $clog2(NR_ENTRIES);

    logic [ID_W-1:0]       head;
    logic [ID_W-1:0]       tail;
    logic [ID_W:0]         count;
    logic [NR_ENTRIES-1:0] occupied;
    scoreboard_entry       mem [NR_ENTRIES];

    logic                  full;
    logic                  issue_fire;
    logic                  commit_valid;
    logic                  commit_fire;
    scoreboard_entry       issue_rec;
    logic [NR_ENTRIES-1:0] rs1_match;
    logic [NR_ENTRIES-1:0] rs2_match;
    logic                  wb_collide;

    // Full comes from the registered count, so a commit in the same cycle
    // does not open a slot for a concurrent issue.
    assign full         = (count == (ID_W+1)'(NR_ENTRIES));
    assign commit_valid = occupied[head] && mem[head].valid;
    assign issue_fire   = sb.issue_valid_i && !full && !sb.flush_i;
    assign commit_fire  = sb.commit_ack_i && commit_valid && !sb.flush_i;

    assign sb.issue_ready_o    = !full;
    assign sb.full_o           = full;
    assign sb.issue_trans_id_o = tail;
    assign sb.commit_valid_o   = commit_valid;
    assign sb.commit_entry_o   = mem[head];

    always_comb begin
        issue_rec          = sb.issue_entry_i;
        issue_rec.trans_id = tail;
        issue_rec.valid    = 1'b0;
    end

    // Register-clobber lookup uses registered state only.
    always_comb begin
        rs1_match = '0;
        rs2_match = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            rs1_match[i] = occupied[i] && (mem[i].rd == sb.rs1_i) && (sb.rs1_i != 5'd0);
            rs2_match[i] = occupied[i] && (mem[i].rd == sb.rs2_i) && (sb.rs2_i != 5'd0);
        end
    end

    assign sb.rs1_busy_o = |rs1_match;
    assign sb.rs2_busy_o = |rs2_match;

    always_ff @(posedge clk_i) begin
        if (rst_i || sb.flush_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            occupied <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else begin
            // Later ports overwrite earlier ones on an id collision.
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (sb.wb_valid_i[p] && occupied[sb.wb_trans_id_i[p]]) begin
                    mem[sb.wb_trans_id_i[p]].result <= sb.wb_data_i[p];
                    mem[sb.wb_trans_id_i[p]].valid  <= 1'b1;
                    if (sb.wb_ex_i[p].valid) begin
                        mem[sb.wb_trans_id_i[p]].ex <= sb.wb_ex_i[p];
                    end
                end
            end

            // The tail slot is never occupied when an issue is accepted, so
            // it cannot clash with the write-back updates above.
            if (issue_fire) begin
                mem[tail]      <= issue_rec;
                occupied[tail] <= 1'b1;
                tail           <= tail + 1'b1;
            end

            if (commit_fire) begin
                occupied[head] <= 1'b0;
                head           <= head + 1'b1;
            end

            case ({issue_fire, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        wb_collide = 1'b0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            for (int q = p + 1; q < NR_WB_PORTS; q++) begin
                if (sb.wb_valid_i[p] && sb.wb_valid_i[q] &&
                    (sb.wb_trans_id_i[p] == sb.wb_trans_id_i[q])) begin
                    wb_collide = 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i && !sb.flush_i) begin
            assert (!wb_collide)
                else $warning("issue_scoreboard: two write-back ports target one trans_id");
        end
    end
`endif

`ifdef SB_FORWARD_EN
    logic [NR_ENTRIES-1:0] rs1_young;
    logic [NR_ENTRIES-1:0] rs2_young;
    logic [63:0]           rs1_fwd;
    logic [63:0]           rs2_fwd;
    logic                  rs1_fwd_valid;
    logic                  rs2_fwd_valid;

    issue_scoreboard_sb_youngest_match #(.NR_ENTRIES(NR_ENTRIES)) u_rs1_young (
        .match_i    (rs1_match),
        .head_i     (head),
        .youngest_o (rs1_young)
    );

    issue_scoreboard_sb_youngest_match #(.NR_ENTRIES(NR_ENTRIES)) u_rs2_young (
        .match_i    (rs2_match),
        .head_i     (head),
        .youngest_o (rs2_young)
    );

    always_comb begin
        rs1_fwd       = '0;
        rs2_fwd       = '0;
        rs1_fwd_valid = 1'b0;
        rs2_fwd_valid = 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (rs1_young[i]) begin
                rs1_fwd       = mem[i].result;
                rs1_fwd_valid = mem[i].valid && !mem[i].ex.valid;
            end
            if (rs2_young[i]) begin
                rs2_fwd       = mem[i].result;
                rs2_fwd_valid = mem[i].valid && !mem[i].ex.valid;
            end
        end
    end

    assign sb.rs1_fwd_o       = rs1_fwd;
    assign sb.rs2_fwd_o       = rs2_fwd;
    assign sb.rs1_fwd_valid_o = rs1_fwd_valid;
    assign sb.rs2_fwd_valid_o = rs2_fwd_valid;
`else
    assign sb.rs1_fwd_o       = '0;
    assign sb.rs2_fwd_o       = '0;
    assign sb.rs1_fwd_valid_o = 1'b0;
    assign sb.rs2_fwd_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_issue_scoreboard
//   Directed test of issue_scoreboard with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    issue_scoreboard_if sb ();

    issue_scoreboard dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb    (sb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic scoreboard_entry mk_entry(input logic [4:0] rd);
        scoreboard_entry e;
        e          = '0;
        e.fu       = FU_ALU;
        e.op       = OP_ADD;
        e.rs1      = 5'd30;
        e.rs2      = 5'd31;
        e.rd       = rd;
        e.trans_id = '1;
        e.valid    = 1'b1;
        e.result   = 64'hDEAD;
        return e;
    endfunction

    task automatic idle_inputs();
        sb.flush_i       = 1'b0;
        sb.issue_valid_i = 1'b0;
        sb.issue_entry_i = '0;
        sb.rs1_i         = 5'd0;
        sb.rs2_i         = 5'd0;
        sb.wb_valid_i    = '0;
        sb.wb_trans_id_i = '0;
        sb.wb_data_i     = '0;
        sb.wb_ex_i       = '0;
        sb.commit_ack_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd);
        sb.issue_valid_i = 1'b1;
        sb.issue_entry_i = mk_entry(rd);
        tick();
        sb.issue_valid_i = 1'b0;
    endtask

    task automatic wb(input int p, input logic [TRANS_ID_BITS-1:0] id,
                      input logic [63:0] d, input exception ex);
        sb.wb_valid_i[p]    = 1'b1;
        sb.wb_trans_id_i[p] = id;
        sb.wb_data_i[p]     = d;
        sb.wb_ex_i[p]       = ex;
        tick();
        sb.wb_valid_i = '0;
        sb.wb_ex_i    = '0;
    endtask

    task automatic ack_one();
        sb.commit_ack_i = 1'b1;
        tick();
        sb.commit_ack_i = 1'b0;
    endtask

    exception no_ex;
    exception ex_hi;
    exception ex_lo;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        no_ex    = '0;
        ex_hi    = '{cause: 64'd2, tval: 64'h1234, valid: 1'b1};
        ex_lo    = '{cause: 64'd7, tval: 64'h0, valid: 1'b0};
        rst      = 1'b1;
        idle_inputs();

        // 1: reset values, fill to full, trans_id wraps
        do_reset();
        sb.rs1_i = 5'd1;
        #1;
        check("rst_ready",    64'(sb.issue_ready_o), 64'd1);
        check("rst_full",     64'(sb.full_o), 64'd0);
        check("rst_cvalid",   64'(sb.commit_valid_o), 64'd0);
        check("rst_busy",     64'(sb.rs1_busy_o), 64'd0);
        check("rst_fwdv",     64'(sb.rs1_fwd_valid_o), 64'd0);
        check("rst_tid",      64'(sb.issue_trans_id_o), 64'd0);
        for (int i = 0; i < 8; i++) begin
            check("fill_tid", 64'(sb.issue_trans_id_o), 64'(i));
            issue(5'(i + 1));
        end
        check("full_full",    64'(sb.full_o), 64'd1);
        check("full_ready",   64'(sb.issue_ready_o), 64'd0);
        check("full_tid",     64'(sb.issue_trans_id_o), 64'd0);
        check("full_busy",    64'(sb.rs1_busy_o), 64'd1);
        sb.rs1_i = 5'd9;
        #1;
        check("full_nobusy",  64'(sb.rs1_busy_o), 64'd0);

        // 2: out-of-order write-back, in-order commit
        do_reset();
        issue(5'd10);
        issue(5'd11);
        issue(5'd12);
        check("ooo_nowb",     64'(sb.commit_valid_o), 64'd0);
        wb(0, 3'd2, 64'hAA, no_ex);
        check("ooo_id2only",  64'(sb.commit_valid_o), 64'd0);
        wb(1, 3'd0, 64'hBB, ex_lo);
        check("ooo_c0v",      64'(sb.commit_valid_o), 64'd1);
        check("ooo_c0data",   sb.commit_entry_o.result, 64'hBB);
        check("ooo_c0tid",    64'(sb.commit_entry_o.trans_id), 64'd0);
        check("ooo_c0rd",     64'(sb.commit_entry_o.rd), 64'd10);
        check("ooo_c0exlo",   sb.commit_entry_o.ex.cause, 64'd0);
        ack_one();
        check("ooo_blk1",     64'(sb.commit_valid_o), 64'd0);
        ack_one();
        check("ooo_blk1b",    64'(sb.commit_valid_o), 64'd0);
        wb(0, 3'd1, 64'hCC, ex_hi);
        check("ooo_c1v",      64'(sb.commit_valid_o), 64'd1);
        check("ooo_c1data",   sb.commit_entry_o.result, 64'hCC);
        check("ooo_c1tid",    64'(sb.commit_entry_o.trans_id), 64'd1);
        check("ooo_c1exv",    64'(sb.commit_entry_o.ex.valid), 64'd1);
        check("ooo_c1exc",    sb.commit_entry_o.ex.cause, 64'd2);
        ack_one();
        check("ooo_c2v",      64'(sb.commit_valid_o), 64'd1);
        check("ooo_c2data",   sb.commit_entry_o.result, 64'hAA);
        check("ooo_c2tid",    64'(sb.commit_entry_o.trans_id), 64'd2);
        ack_one();
        check("ooo_empty",    64'(sb.commit_valid_o), 64'd0);
        check("ooo_tid",      64'(sb.issue_trans_id_o), 64'd3);

        // 3: both write-back ports hit id3 in one cycle; port 1 wins
        do_reset();
        for (int i = 0; i < 4; i++) issue(5'(20 + i));
        sb.wb_valid_i       = 2'b11;
        sb.wb_trans_id_i[0] = 3'd0;
        sb.wb_data_i[0]     = 64'h1;
        sb.wb_trans_id_i[1] = 3'd1;
        sb.wb_data_i[1]     = 64'h2;
        tick();
        sb.wb_valid_i = '0;
        wb(0, 3'd2, 64'h3, no_ex);
        sb.wb_valid_i       = 2'b11;
        sb.wb_trans_id_i[0] = 3'd3;
        sb.wb_data_i[0]     = 64'h11;
        sb.wb_trans_id_i[1] = 3'd3;
        sb.wb_data_i[1]     = 64'h22;
        #1;
        check("col_flag",     64'(dut.wb_collide), 64'd1);
        tick();
        sb.wb_valid_i = '0;
        #1;
        check("col_clear",    64'(dut.wb_collide), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("col_pre",  sb.commit_entry_o.result, 64'(i + 1));
            ack_one();
        end
        check("col_v",        64'(sb.commit_valid_o), 64'd1);
        check("col_tid",      64'(sb.commit_entry_o.trans_id), 64'd3);
        check("col_data",     sb.commit_entry_o.result, 64'h22);

        // 4: full with concurrent commit and issue
        do_reset();
        for (int i = 0; i < 8; i++) issue(5'(i + 1));
        wb(0, 3'd0, 64'h40, no_ex);
        sb.commit_ack_i  = 1'b1;
        sb.issue_valid_i = 1'b1;
        sb.issue_entry_i = mk_entry(5'd20);
        #1;
        check("fc_ready",     64'(sb.issue_ready_o), 64'd0);
        check("fc_cvalid",    64'(sb.commit_valid_o), 64'd1);
        tick();
        sb.commit_ack_i  = 1'b0;
        sb.issue_valid_i = 1'b0;
        check("fc_count",     64'(dut.count), 64'd7);
        check("fc_full",      64'(sb.full_o), 64'd0);
        check("fc_ready2",    64'(sb.issue_ready_o), 64'd1);
        check("fc_tid",       64'(sb.issue_trans_id_o), 64'd0);
        sb.rs1_i = 5'd20;
        #1;
        check("fc_notissued", 64'(sb.rs1_busy_o), 64'd0);
        issue(5'd21);
        check("fc_refull",    64'(sb.full_o), 64'd1);
        check("fc_count8",    64'(dut.count), 64'd8);
        check("fc_slot0rd",   64'(dut.mem[0].rd), 64'd21);
        check("fc_slot0tid",  64'(dut.mem[0].trans_id), 64'd0);
        sb.rs1_i = 5'd21;
        #1;
        check("fc_busy21",    64'(sb.rs1_busy_o), 64'd1);

        // 5: busy and forwarding with two writers of x5
        do_reset();
        issue(5'd5);
        issue(5'd5);
        wb(0, 3'd0, 64'h5, no_ex);
        sb.rs1_i = 5'd5;
        sb.rs2_i = 5'd5;
        #1;
        check("fw_busy1",     64'(sb.rs1_busy_o), 64'd1);
        check("fw_busy2",     64'(sb.rs2_busy_o), 64'd1);
        check("fw_young_nd",  64'(sb.rs1_fwd_valid_o), 64'd0);
        sb.rs1_i = 5'd0;
        #1;
        check("fw_x0busy",    64'(sb.rs1_busy_o), 64'd0);
        check("fw_x0fwdv",    64'(sb.rs1_fwd_valid_o), 64'd0);
        sb.rs1_i = 5'd5;
        wb(1, 3'd1, 64'h77, no_ex);
`ifdef SB_FORWARD_EN
        check("fw_young_v",   64'(sb.rs2_fwd_valid_o), 64'd1);
        check("fw_young_d",   sb.rs2_fwd_o, 64'h77);
`else
        check("fw_young_v",   64'(sb.rs2_fwd_valid_o), 64'd0);
        check("fw_young_d",   sb.rs2_fwd_o, 64'h0);
`endif

        // 6: flush with live entries and concurrent issue / write-back
        do_reset();
        for (int i = 0; i < 5; i++) issue(5'(i + 1));
        wb(0, 3'd1, 64'h9, no_ex);
        sb.flush_i       = 1'b1;
        sb.issue_valid_i = 1'b1;
        sb.issue_entry_i = mk_entry(5'd3);
        sb.wb_valid_i[0]    = 1'b1;
        sb.wb_trans_id_i[0] = 3'd2;
        sb.wb_data_i[0]     = 64'h99;
        tick();
        idle_inputs();
        sb.rs1_i = 5'd3;
        #1;
        check("fl_count",     64'(dut.count), 64'd0);
        check("fl_cvalid",    64'(sb.commit_valid_o), 64'd0);
        check("fl_tid",       64'(sb.issue_trans_id_o), 64'd0);
        check("fl_busy",      64'(sb.rs1_busy_o), 64'd0);
        check("fl_full",      64'(sb.full_o), 64'd0);
        issue(5'd4);
        sb.rs1_i = 5'd4;
        #1;
        check("fl_post_tid",  64'(sb.issue_trans_id_o), 64'd1);
        check("fl_post_busy", 64'(sb.rs1_busy_o), 64'd1);
        check("fl_post_cv",   64'(sb.commit_valid_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
